// File: rtl/bus_arbiter.sv
// Purpose : arbitrates I-cache (c0) and D-cache (c1) onto one shared bus, one transaction at a time.
// Latency : bus_reqcyc rises 1 cycle after a client request; response beats are routed combinationally.
// Backpress: requests wait in IDLE for the previous transaction; response beats stall on the owner's respack.
//
// Ports:
//   clk, reset                         clock, synchronous active-high reset
//   cN_reqcyc/req/reqtag -> cN_reqack  client N request channel (N=0 I-cache, N=1 D-cache)
//   cN_respcyc/resp/resptag <- respack client N response channel
//   bus_reqcyc/req/reqtag <- reqack    shared bus request (registered address/tag)
//   bus_respcyc/resp/resptag -> respack shared bus response
module bus_arbiter #(
  parameter int BUS_DATA_WIDTH = 64,
  parameter int BUS_TAG_WIDTH  = 13,
  parameter int RESP_BEATS     = 8
) (
  input  logic                      clk,
  input  logic                      reset,

  input  logic                      c0_reqcyc,
  input  logic [BUS_DATA_WIDTH-1:0] c0_req,
  input  logic [BUS_TAG_WIDTH-1:0]  c0_reqtag,
  output logic                      c0_reqack,
  output logic                      c0_respcyc,
  output logic [BUS_DATA_WIDTH-1:0] c0_resp,
  output logic [BUS_TAG_WIDTH-1:0]  c0_resptag,
  input  logic                      c0_respack,

  input  logic                      c1_reqcyc,
  input  logic [BUS_DATA_WIDTH-1:0] c1_req,
  input  logic [BUS_TAG_WIDTH-1:0]  c1_reqtag,
  output logic                      c1_reqack,
  output logic                      c1_respcyc,
  output logic [BUS_DATA_WIDTH-1:0] c1_resp,
  output logic [BUS_TAG_WIDTH-1:0]  c1_resptag,
  input  logic                      c1_respack,

  output logic                      bus_reqcyc,
  output logic [BUS_DATA_WIDTH-1:0] bus_req,
  output logic [BUS_TAG_WIDTH-1:0]  bus_reqtag,
  input  logic                      bus_reqack,
  input  logic                      bus_respcyc,
  input  logic [BUS_DATA_WIDTH-1:0] bus_resp,
  input  logic [BUS_TAG_WIDTH-1:0]  bus_resptag,
  output logic                      bus_respack
);

  localparam int CNT_W = $clog2(RESP_BEATS + 1);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(RESP_BEATS - 1);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP} state_t;

  state_t                    r_state;
  logic                      r_owner;      // 0 = c0, 1 = c1
  logic                      r_last;       // client granted most recently
  logic [CNT_W-1:0]          r_cnt;
  logic                      r_bus_reqcyc;
  logic [BUS_DATA_WIDTH-1:0] r_bus_req;
  logic [BUS_TAG_WIDTH-1:0]  r_bus_reqtag;

  logic w_in_req;
  logic w_in_resp;
  logic w_pick;
  logic w_owner_respack;
  logic w_beat;

  assign w_in_req  = (r_state == S_REQ);
  assign w_in_resp = (r_state == S_RESP);

  // On a tie the client not served last wins; a lone requester always wins.
  assign w_pick = (c0_reqcyc && c1_reqcyc) ? ~r_last : c1_reqcyc;

  assign w_owner_respack = r_owner ? c1_respack : c0_respack;
  assign w_beat          = w_in_resp && bus_respcyc && w_owner_respack;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_owner      <= 1'b0;
      r_last       <= 1'b1;   // makes c0 the winner of the first tie
      r_cnt        <= '0;
      r_bus_reqcyc <= 1'b0;
      r_bus_req    <= '0;
      r_bus_reqtag <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (c0_reqcyc || c1_reqcyc) begin
            r_owner      <= w_pick;
            r_last       <= w_pick;
            r_bus_req    <= w_pick ? c1_req    : c0_req;
            r_bus_reqtag <= w_pick ? c1_reqtag : c0_reqtag;
            r_bus_reqcyc <= 1'b1;
            r_state      <= S_REQ;
          end
        end
        S_REQ: begin
          if (bus_reqack) begin
            r_bus_reqcyc <= 1'b0;
            r_cnt        <= '0;
            r_state      <= S_RESP;
          end
        end
        S_RESP: begin
          if (w_beat) begin
            if (r_cnt == LAST_BEAT) begin
              r_cnt   <= '0;
              r_state <= S_IDLE;
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus_reqcyc = r_bus_reqcyc;
  assign bus_req    = r_bus_req;
  assign bus_reqtag = r_bus_reqtag;

  assign c0_reqack = w_in_req && !r_owner && bus_reqack;
  assign c1_reqack = w_in_req &&  r_owner && bus_reqack;

  // Routing relies on the owner register alone; the response tag is passed through unchecked.
  assign c0_respcyc  = w_in_resp && !r_owner && bus_respcyc;
  assign c1_respcyc  = w_in_resp &&  r_owner && bus_respcyc;
  assign c0_resp     = bus_resp;
  assign c1_resp     = bus_resp;
  assign c0_resptag  = bus_resptag;
  assign c1_resptag  = bus_resptag;
  assign bus_respack = w_in_resp && w_owner_respack;

endmodule

// File: tb/tb_bus_arbiter.sv
module tb_bus_arbiter;

  localparam int DW = 64;
  localparam int TW = 13;
  localparam int NB = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          c0_reqcyc, c1_reqcyc, c0_reqack, c1_reqack;
  logic [DW-1:0] c0_req, c1_req, c0_resp, c1_resp;
  logic [TW-1:0] c0_reqtag, c1_reqtag, c0_resptag, c1_resptag;
  logic          c0_respcyc, c1_respcyc, c0_respack, c1_respack;
  logic          bus_reqcyc, bus_reqack, bus_respcyc, bus_respack;
  logic [DW-1:0] bus_req, bus_resp;
  logic [TW-1:0] bus_reqtag, bus_resptag;

  bus_arbiter #(.BUS_DATA_WIDTH(DW), .BUS_TAG_WIDTH(TW), .RESP_BEATS(NB)) dut (
    .clk(clk), .reset(reset),
    .c0_reqcyc(c0_reqcyc), .c0_req(c0_req), .c0_reqtag(c0_reqtag), .c0_reqack(c0_reqack),
    .c0_respcyc(c0_respcyc), .c0_resp(c0_resp), .c0_resptag(c0_resptag), .c0_respack(c0_respack),
    .c1_reqcyc(c1_reqcyc), .c1_req(c1_req), .c1_reqtag(c1_reqtag), .c1_reqack(c1_reqack),
    .c1_respcyc(c1_respcyc), .c1_resp(c1_resp), .c1_resptag(c1_resptag), .c1_respack(c1_respack),
    .bus_reqcyc(bus_reqcyc), .bus_req(bus_req), .bus_reqtag(bus_reqtag), .bus_reqack(bus_reqack),
    .bus_respcyc(bus_respcyc), .bus_resp(bus_resp), .bus_resptag(bus_resptag), .bus_respack(bus_respack)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          own;
    logic [DW-1:0] data;
    logic [TW-1:0] tag;
  } exp_t;

  exp_t req_q[$];
  exp_t resp_q[$];
  int   errors = 0;
  int   checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: pops an expectation whenever the DUT completes a bus handshake.
  always @(negedge clk) begin
    if (bus_reqcyc === 1'b1 && bus_reqack === 1'b1) begin
      check("req_expected", 64'(req_q.size() != 0), 64'd1);
      if (req_q.size() != 0) begin
        exp_t e;
        e = req_q.pop_front();
        check("req_addr", bus_req, e.data);
        check("req_tag", bus_reqtag, e.tag);
        check("req_ack_route", {c1_reqack, c0_reqack}, e.own ? 2'b10 : 2'b01);
      end
    end
    if (bus_respack === 1'b1) begin
      check("resp_expected", 64'(resp_q.size() != 0), 64'd1);
      if (resp_q.size() != 0) begin
        exp_t e;
        e = resp_q.pop_front();
        check("resp_route", {c1_respcyc, c0_respcyc}, e.own ? 2'b10 : 2'b01);
        check("resp_data_c0", c0_resp, e.data);
        check("resp_data_c1", c1_resp, e.data);
        check("resp_tag", e.own ? c1_resptag : c0_resptag, e.tag);
      end
    end
  end

  task automatic set_reqcyc(input int c, input logic v);
    if (c == 0) c0_reqcyc = v; else c1_reqcyc = v;
  endtask

  task automatic set_respack(input int c, input logic v);
    if (c == 0) c0_respack = v; else c1_respack = v;
  endtask

  // Precondition: called just after the clock edge on which the DUT entered REQ for client 'own'.
  task automatic serve(input int own, input logic [DW-1:0] addr, input logic [TW-1:0] tag,
                       input int ack_delay, input int stall_at, input int abort_at);
    exp_t e;
    bit   aborted = 0;
    e.own = own[0]; e.data = addr; e.tag = tag;
    req_q.push_back(e);
    for (int d = 0; d <= ack_delay; d++) begin
      bus_reqack = (d == ack_delay);
      @(negedge clk);
      check("reqcyc_in_req", bus_reqcyc, 1'b1);
      check("req_addr_stable", bus_req, addr);
      check("req_tag_stable", bus_reqtag, tag);
      check("reqack_only_on_ack", {c1_reqack, c0_reqack},
            (d == ack_delay) ? (own ? 2'b10 : 2'b01) : 2'b00);
      @(posedge clk); #1;
    end
    bus_reqack = 1'b0;
    set_reqcyc(own, 1'b0);
    for (int b = 0; b < NB && !aborted; b++) begin
      bus_respcyc = 1'b1;
      bus_resp    = addr + 64'(b);
      bus_resptag = tag;
      if (b == stall_at) begin
        for (int s = 0; s < 3; s++) begin
          set_respack(own, 1'b0);
          set_respack(1 - own, 1'b1);  // non-owner ack must have no effect
          @(negedge clk);
          check("stall_respack", bus_respack, 1'b0);
          check("stall_respcyc", {c1_respcyc, c0_respcyc}, own ? 2'b10 : 2'b01);
          @(posedge clk); #1;
        end
        set_respack(1 - own, 1'b0);
      end
      if (b == abort_at) begin
        set_respack(own, 1'b0);
        reset = 1'b1;
        @(posedge clk); #1;
        c0_respack = 1'b1; c1_respack = 1'b1;
        @(negedge clk);
        check("rst_outputs", {bus_reqcyc, bus_respack, c1_reqack, c0_reqack, c1_respcyc, c0_respcyc}, 6'b0);
        check("rst_bus_req", {bus_reqtag, bus_req}, '0);
        reset = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        check("post_rst_quiet", {bus_reqcyc, bus_respack, c1_respcyc, c0_respcyc}, 4'b0);
        @(posedge clk); #1;
        aborted = 1;
      end else begin
        set_respack(own, 1'b1);
        resp_q.push_back('{own[0], addr + 64'(b), tag});
        @(negedge clk);
        check("beat_respack", bus_respack, 1'b1);
        check("nonowner_reqack", own ? c0_reqack : c1_reqack, 1'b0);
        @(posedge clk); #1;
      end
    end
    if (!aborted) begin
      // One beat past the last must fall into IDLE and be ignored.
      c0_respack = 1'b1; c1_respack = 1'b1;
      @(negedge clk);
      check("idle_after_last_beat", {bus_reqcyc, bus_respack, c1_respcyc, c0_respcyc}, 4'b0);
      @(posedge clk); #1;
    end
    bus_respcyc = 1'b0;
    c0_respack  = 1'b0;
    c1_respack  = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    c0_reqcyc = 0; c1_reqcyc = 0; c0_req = '0; c1_req = '0; c0_reqtag = '0; c1_reqtag = '0;
    c0_respack = 0; c1_respack = 0;
    bus_reqack = 0; bus_respcyc = 0; bus_resp = '0; bus_resptag = '0;
    @(posedge clk); #1;
    @(negedge clk);
    check("reset_outputs", {bus_reqcyc, bus_respack, c1_reqack, c0_reqack, c1_respcyc, c0_respcyc}, 6'b0);
    check("reset_bus_req", bus_req, 64'h0);
    check("reset_bus_tag", bus_reqtag, 13'h0);
    @(posedge clk); #1;
    reset = 1'b0;

    // c0 alone: latched address/tag appear one cycle later, 8 beats to c0.
    c0_reqcyc = 1; c0_req = 64'h1000; c0_reqtag = 13'h5;
    @(negedge clk);
    check("grant_not_before_edge", bus_reqcyc, 1'b0);
    @(posedge clk); #1;
    serve(0, 64'h1000, 13'h5, 0, -1, -1);

    // IDLE with stray bus response: ignored.
    bus_respcyc = 1; c0_respack = 1; c1_respack = 1; bus_resp = 64'hDEAD;
    @(negedge clk);
    check("idle_stray_resp", {bus_respack, c1_respcyc, c0_respcyc}, 3'b0);
    @(posedge clk); #1;
    bus_respcyc = 0; c0_respack = 0; c1_respack = 0;
    @(negedge clk);
    check("idle_stays_idle", bus_reqcyc, 1'b0);
    @(posedge clk); #1;

    // Back to reset so the first tie is resolved from the reset last-grant value.
    reset = 1; @(posedge clk); #1; reset = 0;
    c0_reqcyc = 1; c0_req = 64'h2000; c0_reqtag = 13'h11;
    c1_reqcyc = 1; c1_req = 64'h3000; c1_reqtag = 13'h22;
    @(posedge clk); #1;
    serve(0, 64'h2000, 13'h11, 0, -1, -1);
    serve(1, 64'h3000, 13'h22, 0, -1, -1);
    c0_reqcyc = 1; c0_req = 64'h4000; c0_reqtag = 13'h33;
    c1_reqcyc = 1; c1_req = 64'h5000; c1_reqtag = 13'h44;
    @(posedge clk); #1;
    serve(0, 64'h4000, 13'h33, 0, -1, -1);
    // c1 owner with 3-cycle respack stall before beat 2.
    serve(1, 64'h5000, 13'h44, 0, 2, -1);

    // Delayed bus_reqack by 5 cycles.
    c1_reqcyc = 1; c1_req = 64'h6000; c1_reqtag = 13'h1FFF;
    @(posedge clk); #1;
    serve(1, 64'h6000, 13'h1FFF, 5, -1, -1);

    // Reset at beat 4, then a fresh c1 request runs a full transaction.
    c0_reqcyc = 1; c0_req = 64'h7000; c0_reqtag = 13'h7;
    @(posedge clk); #1;
    serve(0, 64'h7000, 13'h7, 0, -1, 4);
    c1_reqcyc = 1; c1_req = 64'h8000; c1_reqtag = 13'h8;
    @(posedge clk); #1;
    serve(1, 64'h8000, 13'h8, 0, -1, -1);

    repeat (2) @(posedge clk);
    check("req_q_drained", req_q.size(), 0);
    check("resp_q_drained", resp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
